// File: rtl/oled_ctrl_seq.sv
// SSD1306 4-wire SPI OLED controller: panel reset pulse, 25-byte init stream,
// then a single command/data byte-write port onto a mode-0 SPI byte engine.
module oled_ctrl_seq #(
  parameter int SCLK_DIV        = 5,
  parameter int RES_LOW_CYCLES  = 50_000,
  parameter int RES_WAIT_CYCLES = 50_000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       reinit,
  input  logic       wr_valid,
  input  logic       wr_dc,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       oled_res_n,
  output logic       oled_cs_n,
  output logic       oled_dc,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic [2:0] fsm_state
);

  localparam int MAX_WAIT = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int HALF_W   = $clog2(SCLK_DIV);

  localparam logic [CNT_W-1:0]  RES_LOW_LAST  = CNT_W'(RES_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RES_WAIT_LAST = CNT_W'(RES_WAIT_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST     = HALF_W'(SCLK_DIV - 1);
  localparam logic [4:0]        ROM_LAST      = 5'd24;

  typedef enum logic [2:0] {
    RES_LOW   = 3'd0,
    RES_WAIT  = 3'd1,
    INIT_CMD  = 3'd2,
    INIT_WAIT = 3'd3,
    READY     = 3'd4
  } state_t;

  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    init_rom = 8'hAE;
      5'd1:    init_rom = 8'hD5;
      5'd2:    init_rom = 8'h80;
      5'd3:    init_rom = 8'hA8;
      5'd4:    init_rom = 8'h3F;
      5'd5:    init_rom = 8'hD3;
      5'd6:    init_rom = 8'h00;
      5'd7:    init_rom = 8'h40;
      5'd8:    init_rom = 8'h8D;
      5'd9:    init_rom = 8'h14;
      5'd10:   init_rom = 8'h20;
      5'd11:   init_rom = 8'h00;
      5'd12:   init_rom = 8'hA1;
      5'd13:   init_rom = 8'hC8;
      5'd14:   init_rom = 8'hDA;
      5'd15:   init_rom = 8'h12;
      5'd16:   init_rom = 8'h81;
      5'd17:   init_rom = 8'hCF;
      5'd18:   init_rom = 8'hD9;
      5'd19:   init_rom = 8'hF1;
      5'd20:   init_rom = 8'hDB;
      5'd21:   init_rom = 8'h40;
      5'd22:   init_rom = 8'hA4;
      5'd23:   init_rom = 8'hA6;
      default: init_rom = 8'hAF;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       idx, idx_n;
  logic             reinit_pend, reinit_pend_n;

  logic             load;
  logic [7:0]       load_byte;
  logic             load_dc;

  logic             busy;
  logic [HALF_W-1:0] half_cnt;
  logic [4:0]       edge_cnt;
  logic [6:0]       shreg;

  assign fsm_state = state;
  assign wr_ready  = (state == READY) && !busy && !reinit && !reinit_pend;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RES_LOW;
      cnt         <= '0;
      idx         <= '0;
      reinit_pend <= 1'b0;
      oled_res_n  <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      reinit_pend <= reinit_pend_n;
      oled_res_n  <= (state_n != RES_LOW);
      init_done   <= (state_n == READY);
    end
  end

  // Each init byte is launched on the edge that leaves the waiting state, so
  // init bytes follow the same 17*SCLK_DIV+1 cadence as back-to-back writes;
  // INIT_CMD is the single cycle right after a launch.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    idx_n         = idx;
    reinit_pend_n = reinit_pend;
    load          = 1'b0;
    load_byte     = wr_data;
    load_dc       = wr_dc;
    case (state)
      RES_LOW: begin
        reinit_pend_n = 1'b0;
        if (cnt == RES_LOW_LAST) begin
          cnt_n   = '0;
          state_n = RES_WAIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RES_WAIT: begin
        if (cnt == RES_WAIT_LAST) begin
          cnt_n     = '0;
          idx_n     = '0;
          load      = 1'b1;
          load_byte = init_rom(5'd0);
          load_dc   = 1'b0;
          state_n   = INIT_CMD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      INIT_CMD: begin
        state_n = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (!busy) begin
          if (idx == ROM_LAST) begin
            state_n = READY;
          end else begin
            idx_n     = idx + 5'd1;
            load      = 1'b1;
            load_byte = init_rom(idx + 5'd1);
            load_dc   = 1'b0;
            state_n   = INIT_CMD;
          end
        end
      end
      READY: begin
        if (busy) begin
          if (reinit) reinit_pend_n = 1'b1;
        end else if (reinit || reinit_pend) begin
          reinit_pend_n = 1'b0;
          cnt_n         = '0;
          state_n       = RES_LOW;
        end else if (wr_valid) begin
          load = 1'b1;
        end
      end
      default: begin
        state_n = RES_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  // SPI byte engine: edge_cnt counts SCLK half-periods; odd counts are SCLK
  // high, even counts shift MOSI, 16 closes CS and 17 ends the slot.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      half_cnt  <= '0;
      edge_cnt  <= '0;
      shreg     <= '0;
      oled_cs_n <= 1'b1;
      oled_dc   <= 1'b0;
      oled_sclk <= 1'b0;
      oled_mosi <= 1'b0;
    end else if (load) begin
      busy      <= 1'b1;
      half_cnt  <= '0;
      edge_cnt  <= '0;
      shreg     <= load_byte[6:0];
      oled_cs_n <= 1'b0;
      oled_dc   <= load_dc;
      oled_sclk <= 1'b0;
      oled_mosi <= load_byte[7];
    end else if (busy) begin
      if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        edge_cnt <= edge_cnt + 5'd1;
        if (edge_cnt == 5'd16) begin
          busy <= 1'b0;
        end else if (edge_cnt == 5'd15) begin
          oled_sclk <= 1'b0;
          oled_cs_n <= 1'b1;
        end else if (!edge_cnt[0]) begin
          oled_sclk <= 1'b1;
        end else begin
          oled_sclk <= 1'b0;
          oled_mosi <= shreg[6];
          shreg     <= {shreg[5:0], 1'b0};
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule
